// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - shared types and constants for the seven-segment display blocks
package seven_seg_pkg;

   // Scan FSM states: all anodes off between slots, or one digit driven
   typedef enum logic [0:0] {
      ST_BLANK = 1'b0,
      ST_DRIVE = 1'b1
   } scan_state_e;

   // Active-low "everything dark" levels for the segment and decimal-point pins
   localparam logic [6:0] SEG_OFF = 7'b1111111;
   localparam logic       DP_OFF  = 1'b1;

endpackage

// File: rtl/seven_seg_decoder.sv
// rtl/seven_seg_decoder.sv - BCD to active-low seven-segment pattern {g,f,e,d,c,b,a}
module seven_seg_decoder
   import seven_seg_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   // Pure lookup; codes 10..15 are not decimal digits and stay dark
   always_comb begin
      seg = SEG_OFF;
      case (bcd)
         4'd0:    seg = 7'b1000000;
         4'd1:    seg = 7'b1111001;
         4'd2:    seg = 7'b0100100;
         4'd3:    seg = 7'b0110000;
         4'd4:    seg = 7'b0011001;
         4'd5:    seg = 7'b0010010;
         4'd6:    seg = 7'b0000010;
         4'd7:    seg = 7'b1111000;
         4'd8:    seg = 7'b0000000;
         4'd9:    seg = 7'b0010000;
         default: seg = SEG_OFF;
      endcase
   end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// rtl/seven_seg_scan_ctrl.sv - multiplexed scan controller for a common-anode multi-digit display
module seven_seg_scan_ctrl
   import seven_seg_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int DIGIT_CYCLES = 100000,
   parameter int BLANK_CYCLES = 1000
)(
   input  logic                    clk,
   input  logic                    rst,
   input  logic [4*NUM_DIGITS-1:0] value_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    value_load,
   input  logic                    lz_blank_en,
   output logic [NUM_DIGITS-1:0]   an,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic                    frame_done
);

   localparam int MAX_CYCLES = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
   localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
   localparam int IDX_W      = $clog2(NUM_DIGITS);

   localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(DIGIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

   // With no blank interval the FSM never visits ST_BLANK at all
   localparam scan_state_e ST_SLOT_START = (BLANK_CYCLES > 0) ? ST_BLANK : ST_DRIVE;

   scan_state_e               state_q, state_d;
   logic [IDX_W-1:0]          idx_q, idx_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic [4*NUM_DIGITS-1:0]   active_value_q, active_value_d;
   logic [NUM_DIGITS-1:0]     active_dp_q, active_dp_d;
   logic [4*NUM_DIGITS-1:0]   pend_value_q, pend_value_d;
   logic [NUM_DIGITS-1:0]     pend_dp_q, pend_dp_d;
   logic                      pend_flag_q, pend_flag_d;
   logic                      frame_done_q, frame_done_d;

   logic                      boundary;
   logic [NUM_DIGITS-1:0]     lz_mask;
   logic                      upper_zero;
   logic [3:0]                cur_nibble;
   logic                      cur_dp;
   logic                      cur_blank;
   logic [NUM_DIGITS-1:0]     an_sel;
   logic [6:0]                dec_seg;

   // Slot timing, digit rotation, and frame-synchronous promotion of pending data
   always_comb begin
      state_d        = state_q;
      idx_d          = idx_q;
      cnt_d          = cnt_q;
      active_value_d = active_value_q;
      active_dp_d    = active_dp_q;
      pend_value_d   = pend_value_q;
      pend_dp_d      = pend_dp_q;
      pend_flag_d    = pend_flag_q;
      boundary       = 1'b0;

      case (state_q)
         ST_BLANK: begin
            if (cnt_q == BLANK_LAST) begin
               state_d = ST_DRIVE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_DRIVE: begin
            if (cnt_q == DRIVE_LAST) begin
               state_d  = ST_SLOT_START;
               cnt_d    = '0;
               boundary = (idx_q == IDX_LAST);
               idx_d    = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_SLOT_START;
            cnt_d   = '0;
            idx_d   = '0;
         end
      endcase

      // A load on the boundary edge itself bypasses the pending stage
      if (boundary && value_load) begin
         active_value_d = value_in;
         active_dp_d    = dp_in;
         pend_flag_d    = 1'b0;
      end else if (boundary && pend_flag_q) begin
         active_value_d = pend_value_q;
         active_dp_d    = pend_dp_q;
         pend_flag_d    = 1'b0;
      end else if (value_load) begin
         pend_value_d = value_in;
         pend_dp_d    = dp_in;
         pend_flag_d  = 1'b1;
      end

      frame_done_d = boundary;
   end

   // State registers; reset forces the display dark without waiting for a clock
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= ST_SLOT_START;
         idx_q          <= '0;
         cnt_q          <= '0;
         active_value_q <= '0;
         active_dp_q    <= '0;
         pend_value_q   <= '0;
         pend_dp_q      <= '0;
         pend_flag_q    <= 1'b0;
         frame_done_q   <= 1'b0;
      end else begin
         state_q        <= state_d;
         idx_q          <= idx_d;
         cnt_q          <= cnt_d;
         active_value_q <= active_value_d;
         active_dp_q    <= active_dp_d;
         pend_value_q   <= pend_value_d;
         pend_dp_q      <= pend_dp_d;
         pend_flag_q    <= pend_flag_d;
         frame_done_q   <= frame_done_d;
      end
   end

   // Leading-zero mask: a digit is suppressed when it and everything above it is zero
   always_comb begin
      lz_mask    = '0;
      upper_zero = 1'b1;
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
         upper_zero = upper_zero & (active_value_q[4*i +: 4] == 4'd0);
         lz_mask[i] = lz_blank_en & upper_zero;
      end
   end

   // Pick the nibble, dp request, blank flag and anode for the digit being scanned
   always_comb begin
      cur_nibble = 4'd0;
      cur_dp     = 1'b0;
      cur_blank  = 1'b0;
      an_sel     = '1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx_q == IDX_W'(i)) begin
            cur_nibble = active_value_q[4*i +: 4];
            cur_dp     = active_dp_q[i];
            cur_blank  = lz_mask[i];
            an_sel[i]  = 1'b0;
         end
      end
   end

   seven_seg_decoder u_decoder (
      .bcd (cur_nibble),
      .seg (dec_seg)
   );

   // Pin drive: dark during BLANK; a suppressed digit still lights its dp if requested
   always_comb begin
      an  = '1;
      seg = SEG_OFF;
      dp  = DP_OFF;
      if (state_q == ST_DRIVE) begin
         if (!cur_blank) begin
            an  = an_sel;
            seg = dec_seg;
            dp  = ~cur_dp;
         end else if (cur_dp) begin
            an  = an_sel;
            dp  = 1'b0;
         end
      end
   end

   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// tb/tb_seven_seg_scan_ctrl.sv - self-checking bench for seven_seg_scan_ctrl
module tb_seven_seg_scan_ctrl;

   logic        clk;
   logic        rst;
   logic [15:0] value_in;
   logic [3:0]  dp_in;
   logic        value_load;
   logic        lz_blank_en;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic        frame_done;

   seven_seg_scan_ctrl #(
      .NUM_DIGITS   (4),
      .DIGIT_CYCLES (4),
      .BLANK_CYCLES (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .value_in    (value_in),
      .dp_in       (dp_in),
      .value_load  (value_load),
      .lz_blank_en (lz_blank_en),
      .an          (an),
      .seg         (seg),
      .dp          (dp),
      .frame_done  (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
      logic       fd;
   } exp_t;

   typedef struct packed {
      logic [15:0]     val;
      logic [3:0]      dpi;
      logic            lz;
      logic [3:0][6:0] seg;
      logic [3:0]      an_on;
      logic [3:0]      dp_n;
   } vec_t;

   localparam logic [6:0] S0 = 7'b1000000;
   localparam logic [6:0] S1 = 7'b1111001;
   localparam logic [6:0] S2 = 7'b0100100;
   localparam logic [6:0] S3 = 7'b0110000;
   localparam logic [6:0] S4 = 7'b0011001;
   localparam logic [6:0] S5 = 7'b0010010;
   localparam logic [6:0] S6 = 7'b0000010;
   localparam logic [6:0] S7 = 7'b1111000;
   localparam logic [6:0] S8 = 7'b0000000;
   localparam logic [6:0] S9 = 7'b0010000;
   localparam logic [6:0] SX = 7'b1111111;

   exp_t  sb_q[$];
   int    n_checks;
   int    n_fail;
   string cur_tag;
   vec_t  tbl[8];

   function automatic vec_t mk(input logic [15:0] val, input logic [3:0] dpi, input logic lz,
                               input logic [6:0] s3, input logic [6:0] s2,
                               input logic [6:0] s1, input logic [6:0] s0,
                               input logic [3:0] an_on, input logic [3:0] dp_n);
      vec_t v;
      v.val    = val;
      v.dpi    = dpi;
      v.lz     = lz;
      v.seg[3] = s3;
      v.seg[2] = s2;
      v.seg[1] = s1;
      v.seg[0] = s0;
      v.an_on  = an_on;
      v.dp_n   = dp_n;
      return v;
   endfunction

   function automatic exp_t sample_outputs();
      exp_t e;
      e.an  = an;
      e.seg = seg;
      e.dp  = dp;
      e.fd  = frame_done;
      return e;
   endfunction

   task automatic compare(input string name, input exp_t got, input exp_t want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got an=%b seg=%b dp=%b fd=%b, required an=%b seg=%b dp=%b fd=%b",
                  name, got.an, got.seg, got.dp, got.fd, want.an, want.seg, want.dp, want.fd);
      end
   endtask

   // Expected outputs for the first n cycles of a frame, starting at the frame_done cycle
   task automatic push_frame(input vec_t v, input bit fd0, input int n);
      exp_t       e;
      logic [3:0] onehot;
      int         slot;
      int         pos;
      for (int k = 0; k < n; k++) begin
         slot = k / 6;
         pos  = k % 6;
         e.fd = (k == 0) && fd0;
         if (pos < 2) begin
            e.an  = 4'hF;
            e.seg = SX;
            e.dp  = 1'b1;
         end else begin
            onehot = 4'b0001 << slot;
            e.an   = v.an_on[slot] ? ~onehot : 4'hF;
            e.seg  = v.seg[slot];
            e.dp   = v.dp_n[slot];
         end
         sb_q.push_back(e);
      end
   endtask

   task automatic check_now();
      exp_t want;
      if (sb_q.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s sb_underflow: got an=%b seg=%b, required a queued expectation", cur_tag, an, seg);
      end else begin
         want = sb_q.pop_front();
         compare(cur_tag, sample_outputs(), want);
      end
   endtask

   task automatic step_check();
      check_now();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_frame();
      int budget;
      budget = 0;
      while (frame_done !== 1'b1 && budget < 60) begin
         @(posedge clk);
         #1;
         budget++;
      end
      n_checks++;
      if (frame_done !== 1'b1) begin
         n_fail++;
         $display("FAIL %s frame_wait: got frame_done=%b after %0d cycles, required 1", cur_tag, frame_done, budget);
      end
   endtask

   initial begin
      exp_t off;
      exp_t e;
      vec_t v;

      n_checks    = 0;
      n_fail      = 0;
      off         = '{an: 4'hF, seg: SX, dp: 1'b1, fd: 1'b0};

      tbl[0] = mk(16'h1234, 4'b0100, 1'b0, S1, S2, S3, S4, 4'b1111, 4'b1011);
      tbl[1] = mk(16'h0050, 4'b0000, 1'b1, SX, SX, S5, S0, 4'b0011, 4'b1111);
      tbl[2] = mk(16'h0050, 4'b0000, 1'b0, S0, S0, S5, S0, 4'b1111, 4'b1111);
      tbl[3] = mk(16'hA0F0, 4'b0000, 1'b0, SX, S0, SX, S0, 4'b1111, 4'b1111);
      tbl[4] = mk(16'h0000, 4'b0100, 1'b1, SX, SX, SX, S0, 4'b0101, 4'b1011);
      tbl[5] = mk(16'h9876, 4'b1001, 1'b1, S9, S8, S7, S6, 4'b1111, 4'b0110);
      tbl[6] = mk(16'h0005, 4'b0000, 1'b1, SX, SX, SX, S5, 4'b0001, 4'b1111);
      tbl[7] = mk(16'h0A00, 4'b0000, 1'b1, SX, SX, S0, S0, 4'b0111, 4'b1111);

      rst         = 1'b1;
      value_in    = 16'h0;
      dp_in       = 4'h0;
      value_load  = 1'b0;
      lz_blank_en = 1'b0;

      // Reset state before any clock edge
      #1;
      compare("reset_state", sample_outputs(), off);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // Restart timing: two dark cycles, digit 0 shows 0 for four, then next slot
      cur_tag = "restart";
      for (int k = 0; k < 9; k++) begin
         if (k < 2 || k > 5) e = off;
         else e = '{an: 4'b1110, seg: S0, dp: 1'b1, fd: 1'b0};
         if (k == 8) e = '{an: 4'b1101, seg: S0, dp: 1'b1, fd: 1'b0};
         sb_q.push_back(e);
      end
      for (int k = 0; k < 8; k++) step_check();
      check_now();

      // Mid-cycle reset goes dark without a clock edge
      #3;
      rst = 1'b1;
      #1;
      compare("async_reset_mid_cycle", sample_outputs(), off);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Table-driven frames: load mid-frame, check the whole following frame
      for (int t = 0; t < 8; t++) begin
         v = tbl[t];
         $sformat(cur_tag, "vec%0d_%h", t, v.val);
         lz_blank_en = v.lz;
         wait_frame();
         value_in   = v.val;
         dp_in      = v.dpi;
         value_load = 1'b1;
         push_frame(v, 1'b1, 24);
         @(posedge clk);
         #1;
         value_load = 1'b0;
         wait_frame();
         for (int k = 0; k < 24; k++) step_check();
      end

      // Two loads during digit 1: current frame unchanged, last load wins next frame
      cur_tag = "midframe_loads";
      push_frame(tbl[7], 1'b1, 24);
      for (int k = 0; k < 24; k++) begin
         if (k == 8) begin
            value_in   = 16'h1111;
            dp_in      = 4'h0;
            value_load = 1'b1;
         end else if (k == 9) begin
            value_in = 16'h2222;
         end else if (k == 10) begin
            value_load = 1'b0;
         end
         step_check();
      end
      lz_blank_en = 1'b0;

      // Load on the exact boundary edge takes effect in the very next frame
      cur_tag = "last_load_wins";
      push_frame(mk(16'h2222, 4'h0, 1'b0, S2, S2, S2, S2, 4'hF, 4'hF), 1'b1, 24);
      for (int k = 0; k < 24; k++) begin
         if (k == 23) begin
            value_in   = 16'h3333;
            value_load = 1'b1;
         end
         step_check();
      end
      value_load = 1'b0;
      cur_tag = "boundary_load";
      push_frame(mk(16'h3333, 4'h0, 1'b0, S3, S3, S3, S3, 4'hF, 4'hF), 1'b1, 24);
      for (int k = 0; k < 24; k++) step_check();

      // Reset during digit 2 with a load pending: scan restarts at 0, load discarded
      cur_tag = "reset_in_drive";
      push_frame(mk(16'h3333, 4'h0, 1'b0, S3, S3, S3, S3, 4'hF, 4'hF), 1'b1, 15);
      for (int k = 0; k < 14; k++) begin
         if (k == 0) begin
            value_in   = 16'h4321;
            dp_in      = 4'hF;
            value_load = 1'b1;
         end else if (k == 1) begin
            value_load = 1'b0;
         end
         step_check();
      end
      check_now();
      #2;
      rst = 1'b1;
      #1;
      compare("reset_in_drive_dark", sample_outputs(), off);
      @(posedge clk);
      #1;
      rst = 1'b0;
      cur_tag = "after_reset_zero";
      push_frame(mk(16'h0000, 4'h0, 1'b0, S0, S0, S0, S0, 4'hF, 4'hF), 1'b0, 24);
      push_frame(mk(16'h0000, 4'h0, 1'b0, S0, S0, S0, S0, 4'hF, 4'hF), 1'b1, 24);
      for (int k = 0; k < 48; k++) step_check();

      n_checks++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL sb_leftover: got %0d queued entries, required 0", sb_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
